keyword_tokenizer: RTL and testbench

- Upstream stage of the begin/end nesting checker.
- Takes a raw byte stream under a valid/ready handshake and splits it into words on whitespace.
- Classifies each word case-insensitively as BEGIN, END or OTHER, and emits one token per word under a valid/ready handshake.
- Its token stream lets the downstream checker track nesting per word instead of per character.

---
 rtl/keyword_tokenizer.sv | 136 +++++++++++++
 tb/tb_keyword_tokenizer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keyword_tokenizer.sv
// Splits a byte stream into whitespace-separated words and emits one token per word,
// classified case-insensitively as BEGIN, END or OTHER, for the begin/end nesting checker.
module keyword_tokenizer #(
    parameter int LEN_W = 8,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             flush,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [1:0]       tok_kind,
    output logic [LEN_W-1:0] tok_len,
    output logic [IDX_W-1:0] tok_index
);
    typedef enum logic [3:0] {SEP, B1, B2, B3, B4, B5, E1, E2, E3, OTH} state_t;

    localparam logic [31:0]      SEP_CHARS = {8'h20, 8'h09, 8'h0A, 8'h0D};
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX   = '1;
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             tok_valid_reg;
    logic [1:0]       tok_kind_reg;
    logic [LEN_W-1:0] tok_len_reg;
    logic [IDX_W-1:0] tok_index_reg;

    logic [3:0] sep_hit;
    logic       is_sep;
    logic [7:0] folded;
    logic       accept;
    logic       flush_take;
    logic       word_byte;
    logic       term;
    logic       emit;
    logic [1:0] emit_kind;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sep
            assign sep_hit[gi] = (in_char == SEP_CHARS[gi*8 +: 8]);
        end
    endgenerate

    assign is_sep     = |sep_hit;
    assign folded     = (in_char >= 8'h41 && in_char <= 8'h5A) ? (in_char | 8'h20) : in_char;
    assign in_ready   = !tok_valid_reg || tok_ready;
    assign accept     = in_valid && in_ready;
    // Flush only counts when no byte is being offered, so a byte is never lost to it.
    assign flush_take = flush && !in_valid && in_ready;
    assign word_byte  = accept && !is_sep;
    assign term       = (accept && is_sep) || flush_take;
    assign emit       = term && (state_reg != SEP);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SEP;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (word_byte) begin
            case (state_reg)
                SEP:     state_next = (folded == 8'h62) ? B1 : (folded == 8'h65) ? E1 : OTH;
                B1:      state_next = (folded == 8'h65) ? B2 : OTH;
                B2:      state_next = (folded == 8'h67) ? B3 : OTH;
                B3:      state_next = (folded == 8'h69) ? B4 : OTH;
                B4:      state_next = (folded == 8'h6E) ? B5 : OTH;
                E1:      state_next = (folded == 8'h6E) ? E2 : OTH;
                E2:      state_next = (folded == 8'h64) ? E3 : OTH;
                default: state_next = OTH;
            endcase
        end else if (term) begin
            state_next = SEP;
        end
    end

    // Output decode: token class of the word being terminated
    always_comb begin
        emit_kind = 2'd0;
        case (state_reg)
            B5:      emit_kind = 2'd1;
            E3:      emit_kind = 2'd2;
            default: emit_kind = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg <= '0;
            idx_reg <= '0;
        end else if (word_byte) begin
            if (state_reg == SEP) begin
                len_reg <= LEN_ONE;
            end else if (len_reg != LEN_MAX) begin
                len_reg <= len_reg + LEN_ONE;
            end
        end else if (emit) begin
            len_reg <= '0;
            idx_reg <= idx_reg + IDX_ONE;
        end
    end

    // Token register; emit implies in_ready, so a load may coincide with a consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tok_valid_reg <= 1'b0;
            tok_kind_reg  <= 2'd0;
            tok_len_reg   <= '0;
            tok_index_reg <= '0;
        end else if (emit) begin
            tok_valid_reg <= 1'b1;
            tok_kind_reg  <= emit_kind;
            tok_len_reg   <= len_reg;
            tok_index_reg <= idx_reg;
        end else if (tok_ready) begin
            tok_valid_reg <= 1'b0;
        end
    end

    assign tok_valid = tok_valid_reg;
    assign tok_kind  = tok_kind_reg;
    assign tok_len   = tok_len_reg;
    assign tok_index = tok_index_reg;
endmodule

// File: tb/tb_keyword_tokenizer.sv
// Bench for keyword_tokenizer: table-driven word streams scored against a token queue,
// plus hand-written backpressure, saturation and asynchronous reset sequences.
module tb_keyword_tokenizer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        flush;
    logic        tok_valid;
    logic        tok_ready;
    logic [1:0]  tok_kind;
    logic [7:0]  tok_len;
    logic [15:0] tok_index;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  len;
        logic [15:0] idx;
    } tok_t;

    typedef struct {
        string text;
        bit    do_flush;
        bit    lat;
        int    n;
        int    kind[4];
        int    len[4];
    } vec_t;

    tok_t exp_q[$];
    int   exp_idx;

    keyword_tokenizer #(.LEN_W(8), .IDX_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .flush(flush),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_kind(tok_kind), .tok_len(tok_len), .tok_index(tok_index)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare every consumed token with the oldest expectation
    always @(negedge clk) begin
        if (!reset && tok_valid && tok_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_token got kind=%0d len=%0d idx=%0d required none",
                         tok_kind, tok_len, tok_index);
            end else begin
                tok_t e;
                e = exp_q.pop_front();
                if (tok_kind !== e.kind || tok_len !== e.len || tok_index !== e.idx) begin
                    errors++;
                    $display("FAIL token got kind=%0d len=%0d idx=%0d required kind=%0d len=%0d idx=%0d",
                             tok_kind, tok_len, tok_index, e.kind, e.len, e.idx);
                end else begin
                    $display("token kind=%0d len=%0d idx=%0d ok", tok_kind, tok_len, tok_index);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, want);
        end
    endtask

    task automatic expect_tok(input int kind, input int len);
        tok_t t;
        t.kind = kind[1:0];
        t.len  = len[7:0];
        t.idx  = exp_idx[15:0];
        exp_q.push_back(t);
        exp_idx++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        exp_q.delete();
        exp_idx = 0;
    endtask

    // Offer one byte and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] c);
        bit acc;
        int n;
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_char = c;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_flush();
        bit acc;
        @(posedge clk);
        #1 flush = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, int'(tok_valid), 0);
    endtask

    function automatic bit is_sep(input logic [7:0] c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        bit   pending;
        logic [7:0] c;

        tbl[0] = '{"begin end ", 1'b0, 1'b1, 2, '{1, 2, 0, 0}, '{5, 3, 0, 0}};
        tbl[1] = '{"BeGiN\tx\n\015  eNd", 1'b1, 1'b0, 3, '{1, 0, 2, 0}, '{5, 1, 3, 0}};
        tbl[2] = '{"beginx ends beg ", 1'b0, 1'b0, 3, '{0, 0, 0, 0}, '{6, 4, 3, 0}};
        tbl[3] = '{"en b EnD e ", 1'b1, 1'b0, 4, '{0, 0, 2, 0}, '{2, 1, 3, 1}};

        reset = 1'b1;
        in_valid = 1'b0;
        in_char = 8'h00;
        flush = 1'b0;
        tok_ready = 1'b1;
        exp_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tok_valid", int'(tok_valid), 0);
        check("rst_tok_kind", int'(tok_kind), 0);
        check("rst_tok_len", int'(tok_len), 0);
        check("rst_tok_index", int'(tok_index), 0);
        check("rst_in_ready", int'(in_ready), 1);
        #1 reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            do_reset();
            tok_ready = 1'b1;
            for (int k = 0; k < tbl[v].n; k++) expect_tok(tbl[v].kind[k], tbl[v].len[k]);
            pending = 1'b0;
            for (int i = 0; i < tbl[v].text.len(); i++) begin
                c = tbl[v].text[i];
                send_byte(c);
                if (tbl[v].lat && is_sep(c) && pending) begin
                    check("latency_rise", int'(tok_valid), 1);
                    @(posedge clk);
                    #1 check("latency_fall", int'(tok_valid), 0);
                end
                pending = !is_sep(c);
            end
            if (tbl[v].do_flush) send_flush();
            drain($sformatf("case%0d", v));
        end

        // Backpressure: second word must wait while the first token is held
        do_reset();
        tok_ready = 1'b0;
        expect_tok(2, 3);
        expect_tok(1, 5);
        send_str("end ");
        check("bp_valid", int'(tok_valid), 1);
        check("bp_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_char = 8'h62;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_ready", int'(in_ready), 0);
            check("bp_hold_token", int'({tok_kind, tok_len, tok_index}), int'({2'd2, 8'd3, 16'd0}));
        end
        @(posedge clk);
        #1 tok_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        send_str("egin ");
        drain("backpressure");

        // Length saturation
        do_reset();
        expect_tok(0, 255);
        for (int i = 0; i < 300; i++) send_byte(8'h61);
        send_byte(8'h20);
        drain("saturate");

        // Asynchronous reset discards a held token
        do_reset();
        tok_ready = 1'b0;
        send_str("x ");
        check("held_before_reset", int'(tok_valid), 1);
        #2 reset = 1'b1;
        #1;
        check("async_tok_valid", int'(tok_valid), 0);
        check("async_tok_len", int'(tok_len), 0);
        check("async_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        tok_ready = 1'b1;

        // Reset discards a partial word
        send_str("beg");
        do_reset();
        expect_tok(2, 3);
        send_str("end ");
        drain("reset_partial");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
